// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the transmitter and receiver:
//               FSM state encoding, data width, bit-period counter width and
//               an even-parity helper.
//               Optional feature macro: UART_TX_PARITY_EN (selects the PARITY
//               state in uart_tx; the encoding is always present here).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Byte width carried by one UART frame.
  localparam int c_data_w = 8;

  // Bit-period counter width; supports clk_per_bit up to 8191.
  localparam int c_cnt_w  = 13;

  // Frame state encoding, shared by uart_tx and uart_rx.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic parity_even(input logic [c_data_w-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte handshake and line signals of the UART transmitter.
//               master : byte source (drives tx_dv/tx_byte, observes status)
//               slave  : uart_tx    (consumes tx_dv/tx_byte, drives status)
//   tx_dv     byte valid from source
//   tx_byte   byte to send, sampled only on accept
//   tx_ready  a byte can be accepted
//   tx_serial UART line, idles high
//   tx_active a frame is on the line
//   tx_done   one-cycle pulse after the stop bit completes
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
  import uart_pkg::*;

  logic                tx_dv;
  logic [c_data_w-1:0] tx_byte;
  logic                tx_ready;
  logic                tx_serial;
  logic                tx_active;
  logic                tx_done;

  modport master (
    output tx_dv,
    output tx_byte,
    input  tx_ready,
    input  tx_serial,
    input  tx_active,
    input  tx_done
  );

  modport slave (
    input  tx_dv,
    input  tx_byte,
    output tx_ready,
    output tx_serial,
    output tx_active,
    output tx_done
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter. Counts 0..CLK_PER_BIT-1 and returns to 0
//               by itself after the terminal count, so it never wraps.
//   clk    system clock
//   rst    synchronous active-high reset
//   i_clr  hold the counter at zero
//   o_tc   high while the count equals CLK_PER_BIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 5280
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  output logic      o_tc
);

  localparam logic [c_cnt_w-1:0] c_tc_val = c_cnt_w'(CLK_PER_BIT - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  assign o_tc = (cnt_q == c_tc_val);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clr || o_tc) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8N1, LSB first. Accepts one byte per
//               tx_dv/tx_ready handshake and serialises it on tx_serial.
//               Optional feature macro: UART_TX_PARITY_EN adds an even
//               parity bit between the data bits and the stop bit.
//   clk       system clock
//   rst       synchronous active-high reset
//   bus       uart_tx_if.slave (tx_dv, tx_byte in; tx_ready, tx_serial,
//             tx_active, tx_done out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 5280
) (
  input  wire logic  clk,
  input  wire logic  rst,
  uart_tx_if.slave   bus
);

  uart_state_e         state_q,  state_d;
  logic [2:0]          idx_q,    idx_d;
  logic [c_data_w-1:0] shreg_q,  shreg_d;
  logic                serial_q, serial_d;
  logic                active_q, active_d;
  logic                done_q,   done_d;
  logic                ready_q,  ready_d;
  logic                cnt_clr;
  logic                cnt_tc;

  uart_baud_cnt #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (cnt_clr),
    .o_tc  (cnt_tc)
  );

  assign bus.tx_serial = serial_q;
  assign bus.tx_active = active_q;
  assign bus.tx_done   = done_q;
  assign bus.tx_ready  = ready_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    cnt_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clr  = 1'b1;
        serial_d = 1'b1;
        idx_d    = 3'd0;
        if (bus.tx_dv && ready_q) begin
          shreg_d  = bus.tx_byte;
          serial_d = 1'b0;
          active_d = 1'b1;
          ready_d  = 1'b0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (cnt_tc) begin
          serial_d = shreg_q[0];
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_tc) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            // The register is rotated, not shifted, so it still holds every
            // data bit and its XOR equals the parity of the latched byte.
            serial_d = parity_even(shreg_q);
            state_d  = ST_PARITY;
`else
            serial_d = 1'b1;
            state_d  = ST_STOP;
`endif
          end else begin
            idx_d    = idx_q + 3'd1;
            shreg_d  = {shreg_q[0], shreg_q[c_data_w-1:1]};
            serial_d = shreg_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_tc) begin
          serial_d = 1'b1;
          state_d  = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_tc) begin
          serial_d = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        cnt_clr  = 1'b1;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        cnt_clr  = 1'b1;
        serial_d = 1'b1;
        active_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx with CLK_PER_BIT=16.
//               Frame index j counts negedges after the accept edge T0, so
//               the sample at j is the value of cycle T0+j.
//               Honours UART_TX_PARITY_EN for the parity build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_PER_BIT (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observations recorded by watch_frame for later targeted checks.
  int   done_cycle;
  logic par_sample;

  // Independent receiver model sampling mid-bit.
  logic [7:0] rx_q [$];
  logic [7:0] rx_d;
  int         rx_stop_err = 0;
  bit         rx_en = 1'b0;

  initial begin : rx_model
    forever begin
      @(negedge clk);
      if (rx_en && bus.tx_serial === 1'b0) begin
        repeat (N / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (N) @(negedge clk);
          rx_d[k] = bus.tx_serial;
        end
`ifdef UART_TX_PARITY_EN
        repeat (N) @(negedge clk);
`endif
        repeat (N) @(negedge clk);
        if (bus.tx_serial !== 1'b1) rx_stop_err++;
        rx_q.push_back(rx_d);
      end
    end
  end

  function automatic logic exp_serial(input logic [7:0] b, input int j);
    int pos;
    pos = (j - 1) / N;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] b, input string tag);
    @(negedge clk);
    tests_run++;
    if (bus.tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_accept got %b exp 1", tag, bus.tx_ready);
    end
    bus.tx_byte = b;
    bus.tx_dv   = 1'b1;
    @(posedge clk);
  endtask

  // Checks every cycle of a frame from T0+1 to T0+FRAME+2.
  task automatic watch_frame(input logic [7:0] b, input bit keep_dv,
                             input logic [7:0] nb, input int pulse_at,
                             input int abort_at, input string tag);
    done_cycle = -1;
    par_sample = 1'bx;
    for (int j = 1; j <= FRAME + 2; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.tx_byte = nb;
        if (!keep_dv) bus.tx_dv = 1'b0;
      end
      if (j == pulse_at) begin
        bus.tx_dv   = 1'b1;
        bus.tx_byte = 8'hAA;
      end
      if (j == pulse_at + 1) begin
        bus.tx_dv   = 1'b0;
        bus.tx_byte = nb;
      end
      if (bus.tx_done === 1'b1 && done_cycle < 0) done_cycle = j;
      if (j == 9 * N + N / 2) par_sample = bus.tx_serial;

      tests_run++;
      if (bus.tx_serial !== exp_serial(b, j)) begin
        tests_failed++;
        $display("FAIL %s serial j=%0d got %b exp %b", tag, j, bus.tx_serial, exp_serial(b, j));
      end
      tests_run++;
      if (bus.tx_active !== (j <= FRAME)) begin
        tests_failed++;
        $display("FAIL %s active j=%0d got %b exp %b", tag, j, bus.tx_active, (j <= FRAME));
      end
      tests_run++;
      if (bus.tx_done !== (j == FRAME + 1)) begin
        tests_failed++;
        $display("FAIL %s done j=%0d got %b exp %b", tag, j, bus.tx_done, (j == FRAME + 1));
      end
      tests_run++;
      if (bus.tx_ready !== (j == FRAME + 2)) begin
        tests_failed++;
        $display("FAIL %s ready j=%0d got %b exp %b", tag, j, bus.tx_ready, (j == FRAME + 2));
      end
      if (j == abort_at) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      tests_run++;
      if (bus.tx_serial !== 1'b1 || bus.tx_active !== 1'b0 ||
          bus.tx_done !== 1'b0 || bus.tx_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s idle got ser=%b act=%b done=%b rdy=%b exp 1 0 0 1",
                 tag, bus.tx_serial, bus.tx_active, bus.tx_done, bus.tx_ready);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.tx_serial !== 1'b1 || bus.tx_ready !== 1'b1 ||
        bus.tx_active !== 1'b0 || bus.tx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values got ser=%b rdy=%b act=%b done=%b exp 1 1 0 0",
               bus.tx_serial, bus.tx_ready, bus.tx_active, bus.tx_done);
    end
    rst = 1'b0;
    check_idle(4, "after_reset");
  endtask

  task automatic test_single;
    start_frame(8'h55, "single");
    watch_frame(8'h55, 1'b0, 8'h00, -5, -1, "single");
    tests_run++;
    if (done_cycle !== FRAME + 1) begin
      tests_failed++;
      $display("FAIL single done_cycle got %0d exp %0d", done_cycle, FRAME + 1);
    end
  endtask

  task automatic test_back_to_back;
    start_frame(8'h00, "b2b_first");
    watch_frame(8'h00, 1'b1, 8'hFF, -5, -1, "b2b_first");
    // tx_dv is still high, so the next posedge is the second accept edge.
    @(posedge clk);
    watch_frame(8'hFF, 1'b0, 8'h12, -5, -1, "b2b_second");
  endtask

  task automatic test_ignore_busy;
    start_frame(8'h3C, "ignore");
    watch_frame(8'h3C, 1'b0, 8'h3C, 50, -1, "ignore");
    check_idle(6, "ignore_no_queue");
  endtask

  task automatic test_reset_mid_frame;
    start_frame(8'h81, "midrst");
    watch_frame(8'h81, 1'b0, 8'h81, -5, 70, "midrst");
    @(negedge clk);
    tests_run++;
    if (bus.tx_serial !== 1'b1 || bus.tx_ready !== 1'b1 ||
        bus.tx_active !== 1'b0 || bus.tx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_abort got ser=%b rdy=%b act=%b done=%b exp 1 1 0 0",
               bus.tx_serial, bus.tx_ready, bus.tx_active, bus.tx_done);
    end
    rst = 1'b0;
    check_idle(FRAME, "midrst_no_done");
    start_frame(8'h42, "after_midrst");
    watch_frame(8'h42, 1'b0, 8'h00, -5, -1, "after_midrst");
  endtask

  task automatic test_loopback;
    logic [7:0] vec [4];
    vec[0] = 8'h00; vec[1] = 8'hA5; vec[2] = 8'hFF; vec[3] = 8'h7E;
    rx_q.delete();
    rx_stop_err = 0;
    rx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_frame(vec[i], "loopback");
      watch_frame(vec[i], 1'b0, 8'h00, -5, -1, "loopback");
    end
    rx_en = 1'b0;
    tests_run++;
    if (rx_q.size() != 4) begin
      tests_failed++;
      $display("FAIL loopback_count got %0d exp 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (rx_q[i] !== vec[i]) begin
          tests_failed++;
          $display("FAIL loopback_byte%0d got %h exp %h", i, rx_q[i], vec[i]);
        end
      end
    end
    tests_run++;
    if (rx_stop_err != 0) begin
      tests_failed++;
      $display("FAIL loopback_stop got %0d bad stop bits exp 0", rx_stop_err);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    start_frame(8'hA5, "parity_a5");
    watch_frame(8'hA5, 1'b0, 8'h00, -5, -1, "parity_a5");
    tests_run++;
    if (par_sample !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_a5 bit got %b exp 0", par_sample);
    end
    tests_run++;
    if (done_cycle !== 177) begin
      tests_failed++;
      $display("FAIL parity_a5 done_cycle got %0d exp 177", done_cycle);
    end
    start_frame(8'h07, "parity_07");
    watch_frame(8'h07, 1'b0, 8'h00, -5, -1, "parity_07");
    tests_run++;
    if (par_sample !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_07 bit got %b exp 1", par_sample);
    end
  endtask
`endif

  initial begin
    bus.tx_dv   = 1'b0;
    bus.tx_byte = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_loopback();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    check_idle(4, "final");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, 8N1, LSB first; the transmit counterpart to the UART receiver block.
- Accepts one byte per valid/ready handshake from local logic and serialises it onto tx_serial.
- Same bit-period parameterisation as the receiver, so the two loop back directly.
- Sits between the host-side byte source and the board TX pin.

Parameters:
- clk_per_bit, 5280: system clocks per UART bit (clk / baud). Legal range 2..8191. The bit counter is 13 bits.

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- tx_dv  input  1  byte valid from source
- tx_byte  input  8  byte to send; sampled only on accept
- tx_ready  output  1  high when a byte can be accepted (IDLE state)
- tx_serial  output  1  UART line; idles high
- tx_active  output  1  high while a frame is on the line (START through STOP)
- tx_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, tx_serial=1, tx_ready=1, tx_active=0, tx_done=0, counter=0, bit index=0, shift register=0x00.
- Reset mid-frame: on the next posedge, the line returns high immediately and the frame is abandoned. No tx_done pulse.
- Accept rule:
  - The block accepts when tx_dv=1 and tx_ready=1 at a posedge (call this T0).
  - tx_byte is latched into the internal register at T0.
  - tx_dv while tx_ready=0 is ignored, not queued.
- States: IDLE -> START -> DATA -> STOP -> DONE -> IDLE.
  - IDLE: tx_serial=1, counter=0, index=0. Accept moves to START; tx_serial<=0 and tx_active<=1 at T0.
  - START: tx_serial=0 for clk_per_bit cycles. When the counter reaches clk_per_bit-1: counter<=0, drive bit0, go to DATA.
  - DATA: each bit is held for clk_per_bit cycles, bit order byte[0]..byte[7]. At counter=clk_per_bit-1, advance the index; after bit 7, go to STOP.
  - STOP: tx_serial=1 for clk_per_bit cycles. Then go to DONE with tx_active<=0 and tx_done<=1.
  - DONE: one cycle. tx_done=1, tx_serial=1, tx_ready=0. Next state is IDLE with tx_done<=0 and tx_ready<=1.
  - Unreachable state codes go to IDLE with tx_serial=1.
- Timing:
  - Start bit occupies cycles T0+1..T0+clk_per_bit.
  - Bit k occupies T0+(k+1)*clk_per_bit+1 .. T0+(k+2)*clk_per_bit.
  - tx_done is high in cycle T0+10*clk_per_bit+1.
  - tx_ready rises at T0+10*clk_per_bit+2.
  - Minimum frame-to-frame spacing is 10*clk_per_bit+2 cycles.
- Output registering: tx_serial is driven from a flop; there is no combinational path from inputs to tx_serial.
- Counter arithmetic: unsigned 13-bit; comparisons use clk_per_bit-1; the counter never wraps.
- Back-to-back: tx_dv held high continuously sends frames back-to-back at the minimum spacing, each latching the tx_byte present at its own accept edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP, one bit period long.
  - The bit transmitted is even parity, the XOR of the 8 latched data bits.
  - All post-data timing shifts by clk_per_bit: tx_done at T0+11*clk_per_bit+1, tx_ready at T0+11*clk_per_bit+2.
- When undefined: no PARITY state and no parity logic; plain 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (IDLE/START/DATA/STOP/DONE, plus PARITY), used by both uart_tx and uart_rx
  - data width constant (8)
  - counter width constant (13)
- Natural sub-module: uart_baud_cnt. It is a bit-period counter with clear input and a terminal-count output at clk_per_bit-1. It is reusable by the receiver.
- FSM and shift register stay in uart_tx.

Test Plan (clk_per_bit=16 unless stated):
- Reset then tx_byte=0x55 with a one-cycle tx_dv -> tx_serial reads 0,1,0,1,0,1,0,1,0,1, each level exactly 16 cycles starting at T0+1; tx_done is high only at T0+161; tx_ready rises at T0+162.
- tx_byte=0x00 then 0xFF with tx_dv held high -> two frames at exactly 162-cycle spacing; line low 144 cycles then high 16 for the first frame; second frame is start low then 8 data bits high; the second latch occurs at the second accept edge.
- During a 0x3C frame, pulse tx_dv with tx_byte=0xAA at T0+50 -> ignored; only 0x3C is transmitted; the next accept requires tx_ready.
- Assert rst at T0+70 of a 0x81 frame -> tx_serial=1, tx_ready=1, tx_active=0 on the next edge; no tx_done; a new byte 0x42 afterwards transmits cleanly.
- Loopback tx_serial into uart_rx (both clk_per_bit=16), send 0x00, 0xA5, 0xFF, 0x7E -> the receiver reports identical bytes in order.
- UART_TX_PARITY_EN defined: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; tx_done at T0+177.
